// File: rtl/hifq_pkg.sv
// rtl/hifq_pkg.sv - shared types, default sizes and pointer wrap helper for hif_queue_sequencer
package hifq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        ZERO = 2'd2
    } state_t;

    localparam int DEPTH_DEF    = 1536;
    localparam int AW_DEF       = 11;
    localparam int DW_DEF       = 16;
    localparam int READ_LEN_DEF = 1021;

    function automatic int ptr_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/hifq_ptr_sub.sv
// rtl/hifq_ptr_sub.sv - combinational (p - K) mod DEPTH for queue addresses
module hifq_ptr_sub #(
    parameter int DEPTH = 1536,
    parameter int AW    = 11,
    parameter int K     = 1020
) (
    input  logic [AW-1:0] p,
    output logic [AW-1:0] q
);
    logic [AW:0] diff;
    logic [AW:0] wrapped;

    // A set top bit after the subtraction means we borrowed, so fold back into range.
    assign diff    = {1'b0, p} - (AW+1)'(K);
    assign wrapped = diff + (AW+1)'(DEPTH);
    assign q       = diff[AW] ? wrapped[AW-1:0] : diff[AW-1:0];

endmodule

// File: rtl/hif_queue_sequencer.sv
// rtl/hif_queue_sequencer.sv - circular sample queue writer and burst read sequencer; option HIFQ_PRIME_ZERO_EN
module hif_queue_sequencer
    import hifq_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int READ_LEN = READ_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wrt_smpl,
    input  logic [DW-1:0] new_smpl,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_raddr,
    output logic          sequencing,
    output logic          smpl_vld,
    output logic          last_smpl,
    output logic [AW:0]   cnt,
    output logic          overrun
);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_C    = (AW+1)'(READ_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(READ_LEN - 1);

    state_t        state;
    logic [AW-1:0] new_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] seq_idx;
    logic [AW-1:0] start_now;
    logic [AW-1:0] start_prev;
    logic [AW:0]   cnt_next;
    logic          pend;
    logic          accept;
    logic          eligible;
    logic          burst_end;

    // start_now: burst ending at the sample being written; start_prev: ending at the last one written.
    hifq_ptr_sub #(.DEPTH(DEPTH), .AW(AW), .K(READ_LEN - 1)) u_start_now (
        .p (new_ptr),
        .q (start_now)
    );
    hifq_ptr_sub #(.DEPTH(DEPTH), .AW(AW), .K(READ_LEN)) u_start_prev (
        .p (new_ptr),
        .q (start_prev)
    );

    assign accept     = wrt_smpl && (state != ZERO);
    assign cnt_next   = (cnt == DEPTH_C) ? cnt : cnt + (AW+1)'(1);
    assign eligible   = accept && (cnt_next >= LEN_C);
    assign burst_end  = (state == SEQ) && (seq_idx == LAST_IDX);
    assign sequencing = (state == SEQ);
    assign ram_raddr  = rd_ptr;
    assign ram_waddr  = new_ptr;

`ifdef HIFQ_PRIME_ZERO_EN
    logic zeroing;
    assign zeroing   = rst_n && (state == ZERO);
    assign ram_we    = zeroing || wrt_smpl;
    assign ram_wdata = zeroing ? '0 : new_smpl;
`else
    assign ram_we    = wrt_smpl;
    assign ram_wdata = new_smpl;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef HIFQ_PRIME_ZERO_EN
            state     <= ZERO;
`else
            state     <= IDLE;
`endif
            new_ptr   <= '0;
            rd_ptr    <= '0;
            seq_idx   <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            smpl_vld  <= 1'b0;
            last_smpl <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            smpl_vld  <= (state == SEQ);
            last_smpl <= burst_end;
            overrun   <= 1'b0;
            if (accept) begin
                new_ptr <= AW'(ptr_inc(int'(new_ptr), DEPTH));
                cnt     <= cnt_next;
            end
            case (state)
                IDLE: begin
                    if (eligible) begin
                        state   <= SEQ;
                        rd_ptr  <= start_now;
                        seq_idx <= '0;
                    end
                end
                SEQ: begin
                    if (!burst_end) begin
                        rd_ptr  <= AW'(ptr_inc(int'(rd_ptr), DEPTH));
                        seq_idx <= seq_idx + AW'(1);
                        if (eligible) begin
                            pend    <= 1'b1;
                            overrun <= pend;
                        end
                    end else begin
                        // A write landing on the last cycle is the newest sample and wins over pend.
                        seq_idx <= '0;
                        if (eligible) begin
                            rd_ptr  <= start_now;
                            pend    <= 1'b0;
                            overrun <= pend;
                        end else if (pend) begin
                            rd_ptr <= start_prev;
                            pend   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
`ifdef HIFQ_PRIME_ZERO_EN
                ZERO: begin
                    new_ptr <= AW'(ptr_inc(int'(new_ptr), DEPTH));
                    overrun <= wrt_smpl;
                    if (new_ptr == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        cnt   <= DEPTH_C;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hif_queue_sequencer.sv
// tb/tb_hif_queue_sequencer.sv - self-checking bench for hif_queue_sequencer (queue model + directed tests)
module tb_hif_queue_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int RL    = 5;
`ifdef HIFQ_PRIME_ZERO_EN
    localparam int ZERO_EN = 1;
`else
    localparam int ZERO_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wrt_smpl = 1'b0;
    logic [DW-1:0] new_smpl = '0;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic          sequencing;
    logic          smpl_vld;
    logic          last_smpl;
    logic [AW:0]   cnt;
    logic          overrun;

    hif_queue_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .READ_LEN(RL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .new_smpl   (new_smpl),
        .ram_we     (ram_we),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .ram_raddr  (ram_raddr),
        .sequencing (sequencing),
        .smpl_vld   (smpl_vld),
        .last_smpl  (last_smpl),
        .cnt        (cnt),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Stand-in for the parent's RAM with a registered read port.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        rdata <= mem[ram_raddr];
    end

    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of read addresses still to be issued, plus saturating count and write pointer.
    int m_q[$];
    bit m_ql[$];
    int m_mem [DEPTH];
    int m_pend = -1;
    int m_cnt = 0;
    int m_wptr = 0;
    int m_zero = 0;
    int m_vaddr = 0;
    bit m_vld = 0;
    bit m_last = 0;
    bit m_ovr = 0;
    initial for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    function automatic void push_burst(input int a);
        for (int k = 0; k < RL; k++) begin
            m_q.push_back((a - (RL - 1) + k + DEPTH) % DEPTH);
            m_ql.push_back(k == RL - 1);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ql.delete();
            m_pend = -1;
            m_cnt = 0;
            m_wptr = 0;
            m_vld = 0;
            m_last = 0;
            m_ovr = 0;
            m_zero = ZERO_EN ? DEPTH : 0;
        end else begin
            bit busy;
            bit elig;
            int a;
            elig = 0;
            a = 0;
            m_vld = (m_q.size() != 0);
            m_last = m_vld ? m_ql[0] : 1'b0;
            if (m_vld) m_vaddr = m_q[0];
            m_ovr = 0;
            if (m_zero > 0) begin
                m_mem[DEPTH - m_zero] = 0;
                m_zero--;
                if (wrt_smpl) m_ovr = 1;
                if (m_zero == 0) m_cnt = DEPTH;
            end else begin
                if (wrt_smpl) begin
                    a = m_wptr;
                    m_mem[a] = int'(new_smpl);
                    m_wptr = (a + 1) % DEPTH;
                    if (m_cnt < DEPTH) m_cnt++;
                    elig = (m_cnt >= RL);
                end
                busy = (m_q.size() != 0);
                if (busy) begin
                    void'(m_q.pop_front());
                    void'(m_ql.pop_front());
                end
                if (elig) begin
                    if (busy) begin
                        if (m_pend >= 0) m_ovr = 1;
                        m_pend = a;
                    end else begin
                        push_burst(a);
                    end
                end
                if (busy && m_q.size() == 0 && m_pend >= 0) begin
                    push_burst(m_pend);
                    m_pend = -1;
                end
            end
        end
    end

    // Per-cycle comparison and activity monitor, sampled on the falling edge.
    bit chk_en = 0;
    int seen[$];
    int seen_data[$];
    int seq_cycles = 0, seq_rises = 0, last_cnt = 0, ovr_cnt = 0;
    bit prev_seq = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_we;
            bit exp_seq;
            bit in_win;
            exp_we = (rst_n && m_zero > 0) ? 1'b1 : wrt_smpl;
            exp_seq = (m_q.size() != 0);
            chk("ram_we", int'(ram_we), int'(exp_we));
            if (exp_we) begin
                chk("ram_waddr", int'(ram_waddr), (m_zero > 0) ? DEPTH - m_zero : m_wptr);
                chk("ram_wdata", int'(ram_wdata), (m_zero > 0) ? 0 : int'(new_smpl));
            end
            chk("sequencing", int'(sequencing), int'(exp_seq));
            if (exp_seq) chk("ram_raddr", int'(ram_raddr), m_q[0]);
            chk("smpl_vld", int'(smpl_vld), int'(m_vld));
            chk("last_smpl", int'(last_smpl), int'(m_last));
            if (m_vld) chk("rdata", int'(rdata), m_mem[m_vaddr]);
            chk("cnt", int'(cnt), m_cnt);
            chk("overrun", int'(overrun), int'(m_ovr));
            if (ram_we && sequencing) begin
                in_win = 0;
                foreach (m_q[i]) if (m_q[i] == int'(ram_waddr)) in_win = 1;
                chk("waddr_window", int'(in_win), 0);
            end
        end
        if (sequencing) begin
            seen.push_back(int'(ram_raddr));
            seq_cycles++;
            if (!prev_seq) seq_rises++;
        end
        prev_seq = sequencing;
        if (smpl_vld) seen_data.push_back(int'(rdata));
        if (last_smpl) last_cnt++;
        if (overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) tick();
    endtask
    task automatic write(input int v);
        wrt_smpl = 1'b1;
        new_smpl = DW'(v);
        tick();
        wrt_smpl = 1'b0;
    endtask
    task automatic clear();
        seen.delete();
        seen_data.delete();
        seq_cycles = 0;
        seq_rises = 0;
        last_cnt = 0;
        ovr_cnt = 0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask
    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    int exp5[5];
    initial begin
        #2 rst_n = 1'b0;
        chk_en = 1;
        idle(2);
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_seq", int'(sequencing), 0);
        chk("reset_raddr", int'(ram_raddr), 0);
        rst_n = 1'b1;
`ifdef HIFQ_PRIME_ZERO_EN
        // T6: zero priming, a write during it is dropped, first real sample bursts immediately
        clear();
        idle(4);
        write(16'h5555);
        idle(15);
        chk("t6_cnt", int'(cnt), 16);
        chk("t6_ovr", ovr_cnt, 1);
        clear();
        write(16'h1234);
        idle(8);
        exp5 = '{12, 13, 14, 15, 0};
        for (int i = 0; i < 5; i++) chk("t6_raddr", qat(seen, i), exp5[i]);
        exp5 = '{0, 0, 0, 0, 16'h1234};
        for (int i = 0; i < 5; i++) chk("t6_data", qat(seen_data, i), exp5[i]);
`else
        // T1: fill to READ_LEN
        clear();
        for (int i = 0; i < 4; i++) begin
            write(16'h1000 + i);
            idle(2);
        end
        chk("t1_cnt4", int'(cnt), 4);
        chk("t1_noseq", seen.size(), 0);
        write(16'h1004);
        idle(8);
        chk("t1_len", seen.size(), 5);
        exp5 = '{0, 1, 2, 3, 4};
        for (int i = 0; i < 5; i++) chk("t1_raddr", qat(seen, i), exp5[i]);
        for (int i = 0; i < 5; i++) chk("t1_data", qat(seen_data, i), 16'h1000 + i);
        chk("t1_last", last_cnt, 1);

        // T2: wrap around the queue
        do_reset();
        for (int i = 0; i < 19; i++) begin
            write(16'h2000 + i);
            idle(7);
        end
        clear();
        write(16'h2013);
        idle(8);
        exp5 = '{15, 0, 1, 2, 3};
        for (int i = 0; i < 5; i++) chk("t2_raddr", qat(seen, i), exp5[i]);
        chk("t2_cnt_sat", int'(cnt), 16);

        // T3: back-to-back bursts via pend
        clear();
        write(16'h3000);
        tick();
        write(16'h3001);
        idle(14);
        chk("t3_cycles", seq_cycles, 10);
        chk("t3_nogap", seq_rises, 1);
        chk("t3_last", last_cnt, 2);
        chk("t3_ovr", ovr_cnt, 0);
        chk("t3_first", qat(seen, 0), 0);
        chk("t3_second", qat(seen, 5), 1);
        chk("t3_end", qat(seen, 9), 5);

        // T4: overrun keeps only the newest sample
        clear();
        write(16'h4000);
        tick();
        write(16'h4001);
        write(16'h4002);
        idle(14);
        chk("t4_ovr", ovr_cnt, 1);
        chk("t4_cycles", seq_cycles, 10);
        chk("t4_first", qat(seen, 0), 2);
        chk("t4_second", qat(seen, 5), 4);
        chk("t4_end", qat(seen, 9), 8);
        chk("t4_data", qat(seen_data, 9), 16'h4002);

        // T5: asynchronous reset in burst cycle 3
        write(16'h5000);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("t5_seq", int'(sequencing), 0);
        chk("t5_vld", int'(smpl_vld), 0);
        chk("t5_cnt", int'(cnt), 0);
        tick();
        rst_n = 1'b1;
        idle(3);
        chk("t5_idle", int'(sequencing), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
